serial_parity_deserializer: RTL

- Receive side of the serial parity link. The transmitter shifts WIDTH data bits LSB-first, then one XOR parity bit.
- This block rebuilds the parallel word and recomputes parity with a running XOR.
- It presents the word with a parity-error flag on a valid/ready output.
- It sits between the serial line sampler and the word consumer.

---
 rtl/serial_parity_deserializer_if.sv | 23 ++
 rtl/serial_parity_deserializer.sv | 95 +++++++++
 2 files changed

// File: rtl/serial_parity_deserializer_if.sv
// Bundle for the serial parity receiver: serial bit input plus the
// valid/ready word output with parity-error and overflow status.
interface serial_parity_deserializer_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_bit;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_parity_err;
    logic             overflow;

    modport master (
        output in_valid, in_bit, out_ready,
        input  out_valid, out_data, out_parity_err, overflow
    );

    modport slave (
        input  in_valid, in_bit, out_ready,
        output out_valid, out_data, out_parity_err, overflow
    );
endinterface

// File: rtl/serial_parity_deserializer.sv
// Serial parity receiver: collects WIDTH data bits LSB-first plus one parity
// bit, then offers the word and its parity check on a valid/ready output.
module serial_parity_deserializer #(
    parameter int WIDTH      = 8,
    parameter bit ODD_PARITY = 1'b0
) (
    input logic                    clk,
    input logic                    rst,
    serial_parity_deserializer_if.slave bus
);
    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        DATA,
        PARITY
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             running_parity;
    logic [WIDTH-1:0] shreg;
    logic             out_valid_r;
    logic [WIDTH-1:0] out_data_r;
    logic             out_parity_err_r;
    logic             overflow_r;

    logic frame_done;
    logic frame_err;

    always_comb begin
        frame_done = 1'b0;
        frame_err  = 1'b0;
        if (state == PARITY && bus.in_valid) begin
            frame_done = 1'b1;
        end
        frame_err = running_parity ^ bus.in_bit ^ ODD_PARITY;
    end

    // Receive never waits on the consumer; a finished frame that finds the
    // output still occupied is dropped and flagged through overflow instead.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= DATA;
            cnt              <= '0;
            running_parity   <= 1'b0;
            shreg            <= '0;
            out_valid_r      <= 1'b0;
            out_data_r       <= '0;
            out_parity_err_r <= 1'b0;
            overflow_r       <= 1'b0;
        end else begin
            overflow_r <= 1'b0;

            if (out_valid_r && bus.out_ready) begin
                out_valid_r <= 1'b0;
            end

            case (state)
                DATA: begin
                    if (bus.in_valid) begin
                        shreg[cnt]     <= bus.in_bit;
                        running_parity <= running_parity ^ bus.in_bit;
                        if (cnt == LAST_BIT) begin
                            cnt   <= '0;
                            state <= PARITY;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (frame_done) begin
                        running_parity <= 1'b0;
                        state          <= DATA;
                        if (!out_valid_r || bus.out_ready) begin
                            out_valid_r      <= 1'b1;
                            out_data_r       <= shreg;
                            out_parity_err_r <= frame_err;
                        end else begin
                            overflow_r <= 1'b1;
                        end
                    end
                end
                default: state <= DATA;
            endcase
        end
    end

    assign bus.out_valid      = out_valid_r;
    assign bus.out_data       = out_data_r;
    assign bus.out_parity_err = out_parity_err_r;
    assign bus.overflow       = overflow_r;

endmodule
